debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Parametrised N-channel button debouncer, successor to the single-channel shift-register debouncer. Per channel it provides:
- input synchronisation
- sampled debounce with hysteresis: set only on all-ones, clear only on all-zeros
- one-cycle rise and fall pulses
- long-press detection with optional auto-repeat

Sits between board button pins and UI/control logic. The sample tick is generated internally, so no external clock divider is needed.

Parameters:
CHANNELS, 4, number of independent button inputs (>=1)
CLK_FREQ, 12000000, clk frequency in Hz
SAMPLE_HZ, 200, debounce sample rate; DIV = CLK_FREQ/SAMPLE_HZ (integer, >=2)
DEPTH, 8, shift register depth in samples (>=2)
ACTIVE_LOW, 0, 1 = raw inputs are active low; all outputs are always active high
HOLD_SAMPLES, 100, sample ticks of continuous pressed state before the first hold pulse; 0 disables hold/repeat
REPEAT_SAMPLES, 20, sample ticks between repeat hold pulses after the first; 0 = single hold pulse only

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_in  in  CHANNELS  raw button inputs, asynchronous to clk
btn_db  out  CHANNELS  debounced level, 1 = pressed
btn_rise  out  CHANNELS  one-clk pulse on press
btn_fall  out  CHANNELS  one-clk pulse on release
btn_hold  out  CHANNELS  one-clk pulse on long-press / repeat
sample_tick  out  1  one-clk pulse per sample period, for debug/bench alignment

Behaviour:
Reset (async, active-high):
- All outputs and internal state are 0. sample_tick = 0.
- Sync flops and shift registers hold the released state (logical 0 after polarity normalisation).
- Tick counter is 0.

Synchroniser:
- Per channel, 2-FF chain on btn_in, then XOR with ACTIVE_LOW to give normalised level s[i].

Tick generator:
- Counter of width $clog2(DIV) counts 0..DIV-1 and wraps.
- sample_tick is registered high for the one cycle after the counter equals DIV-1, so the first tick after reset is at cycle DIV.
- All channels share the tick.

Shift register (per channel):
- On a cycle with sample_tick=1: sr <= {sr[DEPTH-2:0], s[i]}.
- Otherwise sr holds.

Debounced state (per channel, registered, evaluated on the same edge as the shift):
- If btn_db=0 and the post-shift sr is all ones: btn_db <= 1 and btn_rise <= 1.
- If btn_db=1 and the post-shift sr is all zeros: btn_db <= 0 and btn_fall <= 1.
- Otherwise btn_db holds.
- btn_rise and btn_fall are 0 on every other cycle.
- btn_rise and btn_fall never both assert; each is exactly one clk wide.
- Mixed sr patterns hold the current state (hysteresis).

Latency:
- Clean press: btn_db rises at most 2 + DEPTH*DIV clk cycles after the btn_in edge.
- Release latency is the same.

Hold/repeat (per channel, only when HOLD_SAMPLES>0):
- hold_cnt of width $clog2(max(HOLD_SAMPLES,REPEAT_SAMPLES)+1) is cleared whenever btn_db=0 or btn_rise=1.
- On each tick while btn_db=1, hold_cnt increments.
- First hold: when hold_cnt reaches HOLD_SAMPLES, btn_hold pulses for one clk.
- With REPEAT_SAMPLES>0: hold_cnt reloads to HOLD_SAMPLES-REPEAT_SAMPLES (clamp at 0) and pulses again every REPEAT_SAMPLES ticks.
- With REPEAT_SAMPLES=0: hold_cnt saturates and no further pulses occur until release.
- On release, btn_hold stops immediately. btn_hold never asserts on the same cycle as btn_fall.

Boundary conditions:
- Reset asserted mid-press: all outputs drop to 0 asynchronously; no btn_fall pulse is generated.
- After reset release with the button still held: a fresh btn_rise occurs after DEPTH ticks.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses on the same cycle.
- Input toggling faster than DEPTH ticks never changes btn_db.

Test Plan:
(Bench parameters: CLK_FREQ=1000, SAMPLE_HZ=100 so DIV=10; DEPTH=4, CHANNELS=2, HOLD_SAMPLES=5, REPEAT_SAMPLES=3.)
1. Reset release, btn_in=0 for 200 cycles -> sample_tick every 10 cycles starting at cycle 10; all outputs stay 0.
2. Clean press on ch0 at cycle 5 -> btn_db[0] rises on the 4th tick after sync (cycle 40) with a 1-clk btn_rise[0]. Release -> btn_fall[0] exactly 4 ticks after the sampled 0; ch1 stays 0 throughout.
3. Bounce: ch0 toggles every 15 cycles for 300 cycles, then holds 1 -> no rise during the bounce; a single btn_rise 4 ticks after it settles. Intermittent 0 samples while btn_db=1 cause no fall.
4. Hold: press ch1 for 150 cycles -> btn_hold[1] pulses at 5 ticks after rise, then every 3 ticks (at 5, 8, 11 ticks); release -> btn_fall, with no hold pulse on or after the fall cycle.
5. Async reset asserted mid-press with btn_db[0]=1 -> btn_db drops in the same cycle without a clk edge; no btn_fall. Button still held after reset release -> btn_rise 4 ticks later.
6. ACTIVE_LOW=1 rebuild, btn_in idles at 1 -> no rise after reset; drive 0 -> btn_db=1 after 4 ticks.

Source files
------------

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// debounce_multi : N-channel button debouncer (sync, hysteresis, edges, hold)
// Rev 1.0
// ============================================================================
module debounce_multi #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ       = 12000000,
  parameter int SAMPLE_HZ      = 200,
  parameter int DEPTH          = 8,
  parameter int ACTIVE_LOW     = 0,
  parameter int HOLD_SAMPLES   = 100,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_hold,
  output logic                sample_tick
);

  localparam int DIV    = CLK_FREQ / SAMPLE_HZ;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HMAX   = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
  localparam int HC_W   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
  localparam int RELOAD = (HOLD_SAMPLES > REPEAT_SAMPLES) ? (HOLD_SAMPLES - REPEAT_SAMPLES) : 0;

  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(DIV - 1);
  localparam logic [HC_W-1:0]     HOLD_VAL   = HC_W'(HOLD_SAMPLES);
  localparam logic [HC_W-1:0]     RELOAD_VAL = HC_W'(RELOAD);
  localparam logic [CHANNELS-1:0] POL        = (ACTIVE_LOW != 0) ? '1 : '0;

  // --------------------------------------------------------------------------
  // Shared sample tick
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (tick_cnt == TICK_LAST);
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; flops reset to the released raw level
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= POL;
      sync2 <= POL;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2 ^ POL;

  // --------------------------------------------------------------------------
  // Sample window: the oldest of DEPTH samples is shifted out before it is
  // ever examined, so only DEPTH-1 past samples are stored and the current
  // synchronised level completes the window.
  // --------------------------------------------------------------------------
  logic [DEPTH-2:0]    hist     [CHANNELS];
  logic [DEPTH-1:0]    window   [CHANNELS];
  logic [HC_W-1:0]     hold_cnt [CHANNELS];
  logic [HC_W-1:0]     hold_inc [CHANNELS];
  logic [CHANNELS-1:0] set_now;
  logic [CHANNELS-1:0] clr_now;

  always_comb begin
    set_now = '0;
    clr_now = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      window[c]   = {hist[c], lvl[c]};
      hold_inc[c] = hold_cnt[c] + HC_W'(1);
      set_now[c]  = sample_tick & ~btn_db[c] & (&window[c]);
      clr_now[c]  = sample_tick &  btn_db[c] & ~(|window[c]);
    end
  end

  // --------------------------------------------------------------------------
  // Debounced level, edge pulses and hold/repeat per channel
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db   <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
      btn_hold <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        hist[c]     <= '0;
        hold_cnt[c] <= '0;
      end
    end else begin
      btn_rise <= set_now;
      btn_fall <= clr_now;
      btn_hold <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (sample_tick) begin
          hist[c] <= window[c][DEPTH-2:0];
        end

        if (set_now[c]) begin
          btn_db[c] <= 1'b1;
        end else if (clr_now[c]) begin
          btn_db[c] <= 1'b0;
        end

        // A releasing tick suppresses any hold pulse on the fall cycle.
        if (HOLD_SAMPLES == 0 || !btn_db[c] || btn_rise[c] || clr_now[c]) begin
          hold_cnt[c] <= '0;
        end else if (sample_tick && hold_cnt[c] != HOLD_VAL) begin
          if (hold_inc[c] == HOLD_VAL) begin
            btn_hold[c] <= 1'b1;
            hold_cnt[c] <= (REPEAT_SAMPLES > 0) ? RELOAD_VAL : HOLD_VAL;
          end else begin
            hold_cnt[c] <= hold_inc[c];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// tb_debounce_multi : directed + random checks of two debounce_multi builds
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_debounce_multi;

  localparam int CH     = 2;
  localparam int DIV    = 10;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 5;
  localparam int REPEAT = 3;
  localparam int LAT    = 2 + DEPTH * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] btn_a, btn_b;
  logic [CH-1:0] db_a, rise_a, fall_a, hold_a;
  logic [CH-1:0] db_b, rise_b, fall_b, hold_b;
  logic          tick_a, tick_b;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(CH), .CLK_FREQ(1000), .SAMPLE_HZ(100), .DEPTH(DEPTH),
                   .ACTIVE_LOW(0), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REPEAT)) dut_hi (
    .clk(clk), .rst(rst), .btn_in(btn_a), .btn_db(db_a), .btn_rise(rise_a),
    .btn_fall(fall_a), .btn_hold(hold_a), .sample_tick(tick_a));

  debounce_multi #(.CHANNELS(CH), .CLK_FREQ(1000), .SAMPLE_HZ(100), .DEPTH(DEPTH),
                   .ACTIVE_LOW(1), .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REPEAT)) dut_lo (
    .clk(clk), .rst(rst), .btn_in(btn_b), .btn_db(db_b), .btn_rise(rise_b),
    .btn_fall(fall_b), .btn_hold(hold_b), .sample_tick(tick_b));

  // Reference: ticks from edge arithmetic, debounce from run lengths of
  // identical samples, hold from ticks elapsed since the press.
  int            n_edge;
  logic          e_tick;
  logic [CH-1:0] e_db[2], e_rise[2], e_fall[2], e_hold[2], d1[2], d2[2];
  int            run[2][CH];
  int            held[2][CH];
  bit            lastv[2][CH];
  bit            tick_before, smp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edge = 0;
      e_tick = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_db[k] = '0; e_rise[k] = '0; e_fall[k] = '0; e_hold[k] = '0;
        d1[k] = '0; d2[k] = '0;
        for (int c = 0; c < CH; c++) begin
          run[k][c] = DEPTH; lastv[k][c] = 1'b0; held[k][c] = 0;
        end
      end
    end else begin
      tick_before = (n_edge > 0) && (n_edge % DIV == 0);
      n_edge++;
      for (int k = 0; k < 2; k++) begin
        e_rise[k] = '0; e_fall[k] = '0; e_hold[k] = '0;
        if (tick_before) begin
          for (int c = 0; c < CH; c++) begin
            smp = d2[k][c];
            if (smp == lastv[k][c]) run[k][c]++;
            else begin lastv[k][c] = smp; run[k][c] = 1; end
            if (!e_db[k][c] && smp && run[k][c] >= DEPTH) begin
              e_db[k][c] = 1'b1; e_rise[k][c] = 1'b1; held[k][c] = 0;
            end else if (e_db[k][c] && !smp && run[k][c] >= DEPTH) begin
              e_db[k][c] = 1'b0; e_fall[k][c] = 1'b1;
            end else if (e_db[k][c]) begin
              held[k][c]++;
              if (held[k][c] == HOLD ||
                  (REPEAT > 0 && held[k][c] > HOLD && (held[k][c] - HOLD) % REPEAT == 0))
                e_hold[k][c] = 1'b1;
            end
          end
        end
        d2[k] = d1[k];
        d1[k] = (k == 0) ? btn_a : ~btn_b;
      end
      e_tick = (n_edge % DIV == 0);
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_tick;
  int n_rise[2][CH], n_fall[2][CH], n_hold[2][CH], m_hold[CH];
  int first_rise_cyc[CH], fall_cyc[CH], last_hold_cyc[CH];
  int mark;

  task automatic cmp(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    n_tick = 0;
    for (int c = 0; c < CH; c++) begin
      m_hold[c] = 0; first_rise_cyc[c] = -1; fall_cyc[c] = -1; last_hold_cyc[c] = -1;
      for (int k = 0; k < 2; k++) begin
        n_rise[k][c] = 0; n_fall[k][c] = 0; n_hold[k][c] = 0;
      end
    end
  endtask

  task automatic compare_all();
    cmp1("tick_hi", tick_a, e_tick);
    cmp1("tick_lo", tick_b, e_tick);
    cmp("db_hi",   db_a,   e_db[0]);   cmp("db_lo",   db_b,   e_db[1]);
    cmp("rise_hi", rise_a, e_rise[0]); cmp("rise_lo", rise_b, e_rise[1]);
    cmp("fall_hi", fall_a, e_fall[0]); cmp("fall_lo", fall_b, e_fall[1]);
    cmp("hold_hi", hold_a, e_hold[0]); cmp("hold_lo", hold_b, e_hold[1]);
    n_tick += int'(tick_a);
    for (int c = 0; c < CH; c++) begin
      n_rise[0][c] += int'(rise_a[c]); n_rise[1][c] += int'(rise_b[c]);
      n_fall[0][c] += int'(fall_a[c]); n_fall[1][c] += int'(fall_b[c]);
      n_hold[0][c] += int'(hold_a[c]); n_hold[1][c] += int'(hold_b[c]);
      m_hold[c]    += int'(e_hold[0][c]);
      if (rise_a[c] && first_rise_cyc[c] < 0) first_rise_cyc[c] = cyc;
      if (fall_a[c]) fall_cyc[c] = cyc;
      if (hold_a[c]) last_hold_cyc[c] = cyc;
    end
  endtask

  task automatic step(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cyc++;
      compare_all();
    end
  endtask

  task automatic drive(input logic [CH-1:0] v);
    btn_a = v;
    btn_b = ~v;
  endtask

  initial begin
    btn_a = '0;
    btn_b = '1;
    clear_counts();
    repeat (3) @(negedge clk);
    cmp("reset_db_hi", db_a, '0);
    cmp("reset_db_lo", db_b, '0);
    cmp("reset_pulses", rise_a | fall_a | hold_a | rise_b | fall_b | hold_b, '0);
    cmp1("reset_tick", tick_a, 1'b0);
    rst = 1'b0;

    // Idle: one tick every DIV cycles, nothing else
    step(200);
    chk_int("idle_ticks", n_tick, 200 / DIV);
    chk_int("idle_rises", n_rise[0][0] + n_rise[0][1] + n_rise[1][0] + n_rise[1][1], 0);

    // Clean press and release on ch0
    clear_counts();
    step(5);
    drive(2'b01);
    mark = cyc;
    step(60);
    chk_int("press_rise_count", n_rise[0][0], 1);
    chk_int("press_latency_ok", int'(first_rise_cyc[0] >= 0 && first_rise_cyc[0] - mark <= LAT), 1);
    cmp("press_db_hi", db_a, 2'b01);
    cmp("press_db_activelow", db_b, 2'b01);
    drive(2'b00);
    mark = cyc;
    step(60);
    chk_int("release_fall_count", n_fall[0][0], 1);
    chk_int("release_latency_ok", int'(fall_cyc[0] >= 0 && fall_cyc[0] - mark <= LAT), 1);
    chk_int("ch1_quiet", n_rise[0][1] + n_fall[0][1], 0);

    // Bounce faster than the window, then settle high
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      drive(2'b01); step(15);
      drive(2'b00); step(15);
    end
    chk_int("bounce_no_rise", n_rise[0][0], 0);
    drive(2'b01);
    step(60);
    chk_int("settle_single_rise", n_rise[0][0], 1);
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00); step(15);
      drive(2'b01); step(25);
    end
    chk_int("glitch_no_fall", n_fall[0][0], 0);
    cmp("glitch_db_held", db_a, 2'b01);
    drive(2'b00);
    step(60);

    // Long press on ch1: hold then repeats, none on/after fall
    clear_counts();
    drive(2'b10);
    step(200);
    drive(2'b00);
    step(60);
    chk_int("hold_min_pulses", int'(n_hold[0][1] >= 3), 1);
    chk_int("hold_vs_model", n_hold[0][1], m_hold[1]);
    chk_int("hold_fall_count", n_fall[0][1], 1);
    chk_int("hold_before_fall", int'(fall_cyc[1] >= 0 && last_hold_cyc[1] < fall_cyc[1]), 1);
    chk_int("hold_ch0_quiet", n_hold[0][0], 0);

    // Async reset mid-press, button kept pressed
    drive(2'b11);
    step(60);
    cmp("both_pressed", db_a, 2'b11);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    cmp("async_rst_db_hi", db_a, '0);
    cmp("async_rst_db_lo", db_b, '0);
    cmp("async_rst_no_fall", fall_a | fall_b, '0);
    step(3);
    rst = 1'b0;
    clear_counts();
    step(60);
    chk_int("post_rst_rise", n_rise[0][0], 1);
    chk_int("post_rst_rise_lo", n_rise[1][0], 1);
    chk_int("post_rst_no_fall", n_fall[0][0] + n_fall[0][1], 0);
    cmp("post_rst_db", db_a, 2'b11);
    drive(2'b00);
    step(60);

    // Randomised activity on both builds independently
    for (int s = 0; s < 40; s++) begin
      btn_a = CH'($urandom);
      btn_b = CH'($urandom);
      step($urandom_range(4, 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
